sync_fifo_reader: RTL

Read-side controller for the team's sync_fifo. It drains the FIFO by issuing read requests and captures the registered read data. It presents the words to a downstream consumer on a valid/ready stream through a 2-entry output buffer. It accounts for the FIFO's one-cycle read latency, its one-cycle-late empty flag and its write-over-read priority.

---
 rtl/sync_fifo_reader_if.sv | 25 ++
 rtl/sync_fifo_reader.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/sync_fifo_reader_if.sv
// Stream and FIFO read-side signals of sync_fifo_reader, bundled for port connection.
// slave is the reader's view; master is the view of whatever drives the FIFO and consumer side.
interface sync_fifo_reader_if #(
    parameter int p_DATA_WIDTH  = 8,
    parameter int p_COUNT_WIDTH = 16
);
    logic                     i_FIFO_EMPTY;
    logic [p_DATA_WIDTH-1:0]  i_FIFO_DATA;
    logic                     i_FIFO_WRITE_SNOOP;
    logic                     o_READ_REQUEST;
    logic                     o_VALID;
    logic                     i_READY;
    logic [p_DATA_WIDTH-1:0]  o_DATA;
    logic [p_COUNT_WIDTH-1:0] o_WORDS_READ;

    modport slave (
        input  i_FIFO_EMPTY, i_FIFO_DATA, i_FIFO_WRITE_SNOOP, i_READY,
        output o_READ_REQUEST, o_VALID, o_DATA, o_WORDS_READ
    );

    modport master (
        output i_FIFO_EMPTY, i_FIFO_DATA, i_FIFO_WRITE_SNOOP, i_READY,
        input  o_READ_REQUEST, o_VALID, o_DATA, o_WORDS_READ
    );
endinterface

// File: rtl/sync_fifo_reader.sv
// Drains sync_fifo one word per three cycles into a 2-entry output buffer feeding a valid/ready stream.
// Reads are credit-limited so the buffer can never overflow, and are withheld while the FIFO is being written.
module sync_fifo_reader #(
    parameter int p_DATA_WIDTH  = 8,
    parameter int p_COUNT_WIDTH = 16
) (
    input  logic                  i_CLK,
    input  logic                  i_RESET,
    sync_fifo_reader_if.slave     bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUED  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_t;

    state_t                   r_state;
    logic [1:0]               r_occ;
    logic [p_DATA_WIDTH-1:0]  r_buf0;
    logic [p_DATA_WIDTH-1:0]  r_buf1;
    logic                     r_valid;
    logic [p_COUNT_WIDTH-1:0] r_words;

    logic                     w_in_flight;
    logic                     w_read_req;
    logic                     w_capture;
    logic                     w_pop;
    logic [1:0]               w_occ_next;
    logic [p_DATA_WIDTH-1:0]  w_buf0_next;
    logic [p_DATA_WIDTH-1:0]  w_buf1_next;

    assign w_in_flight = (r_state == ST_ISSUED) || (r_state == ST_CAPTURE);
    assign w_capture   = (r_state == ST_CAPTURE);
    assign w_pop       = r_valid && bus.i_READY;

    // Gated by reset too: the state register already reads IDLE while reset is held.
    assign w_read_req = !i_RESET && (r_state == ST_IDLE) && !bus.i_FIFO_EMPTY
                        && !bus.i_FIFO_WRITE_SNOOP
                        && (({1'b0, r_occ} + {2'b00, w_in_flight}) < 3'd2);

    assign bus.o_READ_REQUEST = w_read_req;
    assign bus.o_VALID        = r_valid;
    assign bus.o_DATA         = r_buf0;
    assign bus.o_WORDS_READ   = r_words;

    // Read sequencer: request, wait out the FIFO read latency, capture.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE:    r_state <= w_read_req ? ST_ISSUED : ST_IDLE;
                ST_ISSUED:  r_state <= ST_CAPTURE;
                ST_CAPTURE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    // Next buffer contents for capture, pop, or both in the same edge (order preserved).
    always_comb begin
        w_occ_next  = r_occ;
        w_buf0_next = r_buf0;
        w_buf1_next = r_buf1;
        case ({w_capture, w_pop})
            2'b10: begin
                if (r_occ == 2'd0) begin
                    w_buf0_next = bus.i_FIFO_DATA;
                end else begin
                    w_buf1_next = bus.i_FIFO_DATA;
                end
                w_occ_next = r_occ + 2'd1;
            end
            2'b01: begin
                w_buf0_next = r_buf1;
                w_occ_next  = r_occ - 2'd1;
            end
            2'b11: begin
                if (r_occ == 2'd1) begin
                    w_buf0_next = bus.i_FIFO_DATA;
                end else begin
                    w_buf0_next = r_buf1;
                    w_buf1_next = bus.i_FIFO_DATA;
                end
            end
            default: begin
                w_occ_next = r_occ;
            end
        endcase
    end

    // Output buffer, valid flag and delivered-word counter.
    always_ff @(posedge i_CLK or posedge i_RESET) begin
        if (i_RESET) begin
            r_occ   <= 2'd0;
            r_buf0  <= '0;
            r_buf1  <= '0;
            r_valid <= 1'b0;
            r_words <= '0;
        end else begin
            r_occ   <= w_occ_next;
            r_buf0  <= w_buf0_next;
            r_buf1  <= w_buf1_next;
            r_valid <= (w_occ_next != 2'd0);
            if (w_pop) begin
                r_words <= r_words + p_COUNT_WIDTH'(1);
            end else begin
                r_words <= r_words;
            end
        end
    end

    sync_fifo_reader_checker u_checker (
        .i_CLK       (i_CLK),
        .i_RESET     (i_RESET),
        .i_occ       (r_occ),
        .i_in_flight (w_in_flight),
        .i_read_req  (w_read_req),
        .i_snoop     (bus.i_FIFO_WRITE_SNOOP)
    );
endmodule

// Safety properties of the reader: buffer bound, credit bound and read spacing.
module sync_fifo_reader_checker (
    input logic       i_CLK,
    input logic       i_RESET,
    input logic [1:0] i_occ,
    input logic       i_in_flight,
    input logic       i_read_req,
    input logic       i_snoop
);
    a_occ_bound: assert property (@(posedge i_CLK) disable iff (i_RESET)
        i_occ <= 2'd2);
    a_credit_bound: assert property (@(posedge i_CLK) disable iff (i_RESET)
        ({1'b0, i_occ} + {2'b00, i_in_flight}) <= 3'd2);
    a_no_read_on_write: assert property (@(posedge i_CLK) disable iff (i_RESET)
        !(i_read_req && i_snoop));
    a_read_spacing: assert property (@(posedge i_CLK) disable iff (i_RESET)
        i_read_req |=> !i_read_req);
endmodule
